// File: rtl/pupil_moment_sequencer_if.sv
// Streaming handshake between the binarizer, the moment sequencer and the
// centre-of-gravity divider: pixel words in, frame moments and status out.
interface pupil_moment_sequencer_if #(
  parameter int BIT_WIDTH = 3,
  parameter int ACC_WIDTH = 32
);
    logic                       sof;
    logic                       valid;
    logic [(1<<BIT_WIDTH)-1:0]  pix;
    logic                       eol;
    logic                       eof;
    logic                       busy;
    logic                       done;
    logic                       abort;
    logic                       ovf;
    logic [ACC_WIDTH-1:0]       area;
    logic [ACC_WIDTH-1:0]       sum_x;
    logic [ACC_WIDTH-1:0]       sum_y;

    modport master (
        output sof, valid, pix, eol, eof,
        input  busy, done, abort, ovf, area, sum_x, sum_y
    );

    modport slave (
        input  sof, valid, pix, eol, eof,
        output busy, done, abort, ovf, area, sum_x, sum_y
    );
endinterface

// File: rtl/pupil_moment_sequencer.sv
// Accumulates area and first moments (sum x, sum y) of a binarized frame
// streamed word by word, and sequences frame start, flush, done and abort.
module pupil_moment_sequencer #(
    parameter int BIT_WIDTH = 3,
    parameter int XW_LOG    = 7,
    parameter int Y_LOG     = 9,
    parameter int ACC_WIDTH = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    pupil_moment_sequencer_if.slave bus
);

    localparam int NPIX    = 1 << BIT_WIDTH;
    localparam int PC_W    = BIT_WIDTH + 1;
    localparam int BX_W    = 2 * BIT_WIDTH;
    localparam int XINC_W  = 2 * BIT_WIDTH + 2 + XW_LOG;
    localparam int YINC_W  = PC_W + Y_LOG;
    localparam int MAX_W0  = (XINC_W > YINC_W) ? XINC_W : YINC_W;
    // One spare bit above everything so a saturating add can see the carry.
    localparam int EW      = ((ACC_WIDTH > MAX_W0) ? ACC_WIDTH : MAX_W0) + 1;

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DONE} state_t;

    function automatic logic [PC_W-1:0] popcount(input logic [NPIX-1:0] w);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < NPIX; i++) n = n + PC_W'(w[i]);
        return n;
    endfunction

    // Sum of bit indices of set pixels, built from per-index-bit masks.
    function automatic logic [BX_W-1:0] bit_moment(input logic [NPIX-1:0] w);
        logic [BX_W-1:0] s;
        logic [NPIX-1:0] m;
        s = '0;
        for (int k = 0; k < BIT_WIDTH; k++) begin
            for (int i = 0; i < NPIX; i++) m[i] = 1'((i >> k) & 1);
            s = s + (BX_W'(popcount(w & m)) << k);
        end
        return s;
    endfunction

    function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] acc,
                                                   input logic [EW-1:0] inc);
        logic [EW-1:0] sum;
        sum = EW'(acc) + inc;
        if (sum > {{(EW-ACC_WIDTH){1'b0}}, {ACC_WIDTH{1'b1}}})
            return {1'b1, {ACC_WIDTH{1'b1}}};
        return {1'b0, sum[ACC_WIDTH-1:0]};
    endfunction

    state_t                 state;
    logic                   flush_cnt;
    logic                   busy_r, done_r, abort_r, ovf_r;
    logic [ACC_WIDTH-1:0]   area_r, sum_x_r, sum_y_r;

    logic [XW_LOG-1:0]      word_x, base_x, next_x;
    logic [Y_LOG-1:0]       word_y, base_y, next_y;
    logic                   coord_ovf;
    logic                   take;
    logic                   in_frame;

    logic                   vld_p1;
    logic [PC_W-1:0]        pc_p1;
    logic [BX_W-1:0]        bx_p1;
    logic [XW_LOG-1:0]      x_p1;
    logic [Y_LOG-1:0]       y_p1;

    logic [ACC_WIDTH-1:0]   area_p2, sumx_p2, sumy_p2;
    logic                   ovf_pend;

    logic [EW-1:0]          inc_area, inc_x, inc_y;
    logic [ACC_WIDTH:0]     area_nx, sumx_nx, sumy_nx;

    assign in_frame = (state == ACCUM) || (state == FLUSH);
    assign take     = bus.valid && (bus.sof || state == ACCUM);

    // Coordinates restart at the origin when the word arrives with sof.
    always_comb begin
        base_x    = bus.sof ? '0 : word_x;
        base_y    = bus.sof ? '0 : word_y;
        next_x    = base_x;
        next_y    = base_y;
        coord_ovf = 1'b0;
        if (take) begin
            if (bus.eol) begin
                next_x = '0;
                if (&base_y) coord_ovf = 1'b1;
                else         next_y    = base_y + Y_LOG'(1);
            end else begin
                if (&base_x) coord_ovf = 1'b1;
                else         next_x    = base_x + XW_LOG'(1);
            end
        end
    end

    // Stage 1: popcount and in-word x moment of the accepted word.
    always_ff @(posedge clk) begin
        if (take) begin
            pc_p1 <= popcount(bus.pix);
            bx_p1 <= bit_moment(bus.pix);
            x_p1  <= base_x;
            y_p1  <= base_y;
        end
    end

    assign inc_area = EW'(pc_p1);
    assign inc_x    = ((EW'(pc_p1) * EW'(x_p1)) << BIT_WIDTH) + EW'(bx_p1);
    assign inc_y    = EW'(pc_p1) * EW'(y_p1);
    assign area_nx  = sat_add(area_p2, inc_area);
    assign sumx_nx  = sat_add(sumx_p2, inc_x);
    assign sumy_nx  = sat_add(sumy_p2, inc_y);

    // Stage 2: saturating accumulation; sof discards the in-flight word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            word_x   <= '0;
            word_y   <= '0;
            area_p2  <= '0;
            sumx_p2  <= '0;
            sumy_p2  <= '0;
            ovf_pend <= 1'b0;
        end else begin
            vld_p1 <= take;
            word_x <= next_x;
            word_y <= next_y;
            if (bus.sof) begin
                area_p2  <= '0;
                sumx_p2  <= '0;
                sumy_p2  <= '0;
                ovf_pend <= coord_ovf;
            end else if (vld_p1) begin
                area_p2  <= area_nx[ACC_WIDTH-1:0];
                sumx_p2  <= sumx_nx[ACC_WIDTH-1:0];
                sumy_p2  <= sumy_nx[ACC_WIDTH-1:0];
                ovf_pend <= ovf_pend | coord_ovf | area_nx[ACC_WIDTH]
                          | sumx_nx[ACC_WIDTH] | sumy_nx[ACC_WIDTH];
            end else begin
                ovf_pend <= ovf_pend | coord_ovf;
            end
        end
    end

    // Frame sequencer; flush covers the two pipeline stages before results latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            flush_cnt <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            abort_r   <= 1'b0;
            ovf_r     <= 1'b0;
            area_r    <= '0;
            sum_x_r   <= '0;
            sum_y_r   <= '0;
        end else begin
            done_r  <= 1'b0;
            abort_r <= 1'b0;
            if (bus.sof) begin
                state     <= ACCUM;
                flush_cnt <= 1'b0;
                busy_r    <= 1'b1;
                abort_r   <= in_frame;
            end else begin
                case (state)
                    IDLE: busy_r <= 1'b0;
                    ACCUM: begin
                        if (bus.eof) begin
                            state     <= FLUSH;
                            flush_cnt <= 1'b0;
                        end
                    end
                    FLUSH: begin
                        if (flush_cnt) begin
                            state   <= DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            ovf_r   <= ovf_pend;
                            area_r  <= area_p2;
                            sum_x_r <= sumx_p2;
                            sum_y_r <= sumy_p2;
                        end else begin
                            flush_cnt <= 1'b1;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.abort = abort_r;
    assign bus.ovf   = ovf_r;
    assign bus.area  = area_r;
    assign bus.sum_x = sum_x_r;
    assign bus.sum_y = sum_y_r;

endmodule

// File: tb/tb_pupil_moment_sequencer.sv
// Directed bench: a 32-bit instance checks frame moments and sequencing,
// a 4-bit-accumulator instance checks saturation and the overflow flag.
module tb_pupil_moment_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pupil_moment_sequencer_if #(.BIT_WIDTH(3), .ACC_WIDTH(32)) ifa ();
    pupil_moment_sequencer_if #(.BIT_WIDTH(3), .ACC_WIDTH(4))  ifb ();

    pupil_moment_sequencer #(.BIT_WIDTH(3), .XW_LOG(7), .Y_LOG(9), .ACC_WIDTH(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    pupil_moment_sequencer #(.BIT_WIDTH(3), .XW_LOG(7), .Y_LOG(9), .ACC_WIDTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic v, input logic [7:0] p,
                         input logic l, input logic e);
        ifa.sof = s; ifa.valid = v; ifa.pix = p; ifa.eol = l; ifa.eof = e;
        ifb.sof = s; ifb.valid = v; ifb.pix = p; ifb.eol = l; ifb.eof = e;
        @(posedge clk);
        @(negedge clk);
        ifa.sof = 1'b0; ifa.valid = 1'b0; ifa.pix = '0; ifa.eol = 1'b0; ifa.eof = 1'b0;
        ifb.sof = 1'b0; ifb.valid = 1'b0; ifb.pix = '0; ifb.eol = 1'b0; ifb.eof = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Called right after the step carrying eof: done must appear exactly two steps later.
    task automatic expect_done_a(input string tag, input int a, input int sx, input int sy,
                                 input logic o);
        idle();
        check({tag, "_done_early"}, 32'(ifa.done), 32'd0);
        idle();
        check({tag, "_done"}, 32'(ifa.done), 32'd1);
        check({tag, "_busy"}, 32'(ifa.busy), 32'd0);
        check({tag, "_area"}, ifa.area, 32'(a));
        check({tag, "_sum_x"}, ifa.sum_x, 32'(sx));
        check({tag, "_sum_y"}, ifa.sum_y, 32'(sy));
        check({tag, "_ovf"}, 32'(ifa.ovf), 32'(o));
        idle();
        check({tag, "_done_pulse"}, 32'(ifa.done), 32'd0);
    endtask

    initial begin
        ifa.sof = 1'b0; ifa.valid = 1'b0; ifa.pix = '0; ifa.eol = 1'b0; ifa.eof = 1'b0;
        ifb.sof = 1'b0; ifb.valid = 1'b0; ifb.pix = '0; ifb.eol = 1'b0; ifb.eof = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(ifa.busy), 32'd0);
        check("rst_done", 32'(ifa.done), 32'd0);
        check("rst_area", ifa.area, 32'd0);
        rst_n = 1'b1;
        idle();

        // Single pixel at x=13, y=1.
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check("t1_busy", 32'(ifa.busy), 32'd1);
        drive(1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'h20, 1'b0, 1'b1);
        check("t1_flush_busy", 32'(ifa.busy), 32'd1);
        expect_done_a("t1", 1, 13, 1, 1'b0);

        // Full word at origin.
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'hFF, 1'b0, 1'b1);
        expect_done_a("t2", 8, 28, 0, 1'b0);

        // 4 lines x 2 full words, eof on its own afterwards.
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int ln = 0; ln < 4; ln++) begin
            drive(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
            drive(1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        expect_done_a("t3", 64, 480, 96, 1'b0);

        // Restart mid-frame: abort once, old results held, new frame clean.
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
        check("t4_no_abort_yet", 32'(ifa.abort), 32'd0);
        drive(1'b1, 1'b1, 8'h01, 1'b0, 1'b0);
        check("t4_abort", 32'(ifa.abort), 32'd1);
        check("t4_area_held", ifa.area, 32'd64);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("t4_abort_pulse", 32'(ifa.abort), 32'd0);
        expect_done_a("t4", 1, 0, 0, 1'b0);

        // Three full words: 32-bit instance exact, 4-bit instance saturates.
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'hFF, 1'b0, 1'b1);
        idle();
        idle();
        check("t5b_done", 32'(ifb.done), 32'd1);
        check("t5b_area", 32'(ifb.area), 32'd15);
        check("t5b_sum_x", 32'(ifb.sum_x), 32'd15);
        check("t5b_sum_y", 32'(ifb.sum_y), 32'd0);
        check("t5b_ovf", 32'(ifb.ovf), 32'd1);
        check("t5a_area", ifa.area, 32'd24);
        check("t5a_sum_x", ifa.sum_x, 32'd276);
        check("t5a_ovf", 32'(ifa.ovf), 32'd0);
        idle();

        // Clean frame clears the overflow flag.
        drive(1'b1, 1'b1, 8'h01, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        idle();
        idle();
        check("t6b_done", 32'(ifb.done), 32'd1);
        check("t6b_area", 32'(ifb.area), 32'd1);
        check("t6b_ovf", 32'(ifb.ovf), 32'd0);
        idle();

        // Frame with no valid words.
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        expect_done_a("t7", 0, 0, 0, 1'b0);

        // Words outside a frame are ignored.
        drive(1'b0, 1'b1, 8'hFF, 1'b0, 1'b1);
        idle();
        idle();
        check("t8_ignored_done", 32'(ifa.done), 32'd0);
        check("t8_ignored_busy", 32'(ifa.busy), 32'd0);

        // Reset during accumulation after a frame with nonzero results.
        drive(1'b1, 1'b1, 8'h80, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        expect_done_a("t9", 1, 7, 0, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
        check("t10_busy_pre", 32'(ifa.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t10_busy_rst", 32'(ifa.busy), 32'd0);
        check("t10_area_rst", ifa.area, 32'd0);
        check("t10_sum_x_rst", ifa.sum_x, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle();
            check("t10_no_done", 32'(ifa.done | ifa.abort), 32'd0);
        end

        // Frame after reset, pixel at x=9, y=1.
        drive(1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'h02, 1'b0, 1'b1);
        expect_done_a("t11", 1, 9, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
